// File: rtl/poker_pkg.sv
// Card encoding constants and helpers for the poker datapath.
// A card is {suit[1:0], rank[3:0]} with ranks 2..14 (ace high).
package poker_pkg;

    localparam int CARD_W    = 6;
    localparam int DECK_SIZE = 52;
    localparam int RANK_MIN  = 2;
    localparam int RANK_ACE  = 14;
    localparam int SUIT_MSB  = 5;
    localparam int SUIT_LSB  = 4;
    localparam int RANK_MSB  = 3;
    localparam int RANK_LSB  = 0;

    // Card slot layout of the dealt bus: player, dealer, community.
    localparam int SLOT_PLAYER    = 0;
    localparam int N_PLAYER       = 2;
    localparam int SLOT_DEALER    = 2;
    localparam int N_DEALER       = 2;
    localparam int SLOT_COMMUNITY = 4;
    localparam int N_COMMUNITY    = 5;

    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic logic [CARD_W-1:0] index_to_card(input logic [5:0] idx);
        logic [1:0] suit;
        logic [5:0] rem;
        if (idx < 6'd13) begin
            suit = 2'd0;
            rem  = idx;
        end else if (idx < 6'd26) begin
            suit = 2'd1;
            rem  = idx - 6'd13;
        end else if (idx < 6'd39) begin
            suit = 2'd2;
            rem  = idx - 6'd26;
        end else begin
            suit = 2'd3;
            rem  = idx - 6'd39;
        end
        return {suit, rem[3:0] + 4'(RANK_MIN)};
    endfunction

endpackage

// File: rtl/card_dealer_if.sv
// Request/result bundle between the game controller (master) and the dealer (slave).
interface card_dealer_if #(
    parameter int NUM_CARDS = 9
);
    logic                     draw_card;
    logic                     seed_load;
    logic [15:0]              seed;
    logic [6*NUM_CARDS-1:0]   dealt_cards;
    logic                     all_cards_dealt;
    logic [3:0]               dealt_count;
    logic                     busy;

    modport master (
        output draw_card, seed_load, seed,
        input  dealt_cards, all_cards_dealt, dealt_count, busy
    );

    modport slave (
        input  draw_card, seed_load, seed,
        output dealt_cards, all_cards_dealt, dealt_count, busy
    );
endinterface

// File: rtl/lfsr16.sv
// Free-running Fibonacci LFSR (x^16+x^14+x^13+x^11+1) with a seed load port.
// A zero seed would lock the register, so it is replaced by the default seed.
module lfsr16
    import poker_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic [15:0] seed_i,
    output logic [5:0]  cand_o
);
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;

    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        if (load_i) begin
            lfsr_d = (seed_i == 16'h0000) ? SEED_EFF : seed_i;
        end else begin
            lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr_q <= SEED_EFF;
        else        lfsr_q <= lfsr_d;
    end

    assign cand_o = lfsr_q[5:0];
endmodule

// File: rtl/card_dealer.sv
// Deals NUM_CARDS distinct cards from a 52-card deck, one LFSR candidate per cycle,
// with a lowest-unused-card fallback after MAX_REJECT consecutive rejects.
module card_dealer
    import poker_pkg::*;
#(
    parameter int          NUM_CARDS  = 9,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int          MAX_REJECT = 7
) (
    input logic           clk,
    input logic           reset_n,
    card_dealer_if.slave  bus
);
    localparam int DW = CARD_W * NUM_CARDS;
    localparam int RW = $clog2(MAX_REJECT + 2);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_DRAW  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [63:0]       used_q, used_d;
    logic [DW-1:0]     cards_q, cards_d;
    logic [3:0]        count_q, count_d;
    logic [RW-1:0]     rej_q, rej_d;
    logic              done_q, done_d;

    logic [5:0]        cand;
    logic [5:0]        scan_idx;
    logic [5:0]        pick_idx;
    logic              rand_ok;
    logic              rej_over;
    logic              take;
    logic [CARD_W-1:0] card;
    logic [CARD_W-1:0] card_rev;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk    (clk),
        .rst_n  (reset_n),
        .load_i (bus.seed_load),
        .seed_i (bus.seed),
        .cand_o (cand)
    );

    // Descending scan so the lowest unused index wins.
    always_comb begin
        scan_idx = '0;
        for (int i = DECK_SIZE - 1; i >= 0; i--) begin
            if (!used_q[i]) scan_idx = 6'(i);
        end
    end

    always_comb begin
        rand_ok  = (cand < 6'(DECK_SIZE)) && !used_q[cand];
        rej_over = (rej_q == RW'(MAX_REJECT));
        take     = rand_ok || rej_over;
        pick_idx = rand_ok ? cand : scan_idx;
        card     = index_to_card(pick_idx);
        card_rev = '0;
        for (int j = 0; j < CARD_W; j++) card_rev[j] = card[CARD_W-1-j];
    end

    always_comb begin
        state_d = state_q;
        used_d  = used_q;
        cards_d = cards_q;
        count_d = count_q;
        rej_d   = rej_q;
        done_d  = done_q;
        case (state_q)
            S_IDLE: begin
                if (bus.draw_card) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                used_d  = '0;
                cards_d = '0;
                count_d = '0;
                rej_d   = '0;
                done_d  = 1'b0;
                state_d = bus.draw_card ? S_DRAW : S_IDLE;
            end
            S_DRAW: begin
                if (!bus.draw_card) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end else if (take) begin
                    for (int k = 0; k < NUM_CARDS; k++) begin
                        if (4'(k) == count_q) cards_d[k*CARD_W +: CARD_W] = card_rev;
                    end
                    used_d[pick_idx] = 1'b1;
                    count_d          = count_q + 4'd1;
                    rej_d            = '0;
                    if (count_q == 4'(NUM_CARDS - 1)) state_d = S_DONE;
                end else begin
                    rej_d = rej_q + 1'b1;
                end
            end
            S_DONE: begin
                // Flag follows the request; dropping it acknowledges and returns to idle.
                done_d = bus.draw_card;
                if (!bus.draw_card) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            used_q  <= '0;
            cards_q <= '0;
            count_q <= '0;
            rej_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            used_q  <= used_d;
            cards_q <= cards_d;
            count_q <= count_d;
            rej_q   <= rej_d;
            done_q  <= done_d;
        end
    end

    assign bus.dealt_cards     = cards_q;
    assign bus.all_cards_dealt = done_q;
    assign bus.dealt_count     = count_q;
    assign bus.busy            = (state_q == S_CLEAR) || (state_q == S_DRAW);
endmodule

// File: tb/tb_card_dealer.sv
// Bench for card_dealer: seeded deals checked against a reference deal model via a
// scoreboard queue, plus reset, abort, acknowledge and scan-fallback sequences.
module tb_card_dealer;
    localparam int NC = 9;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    card_dealer_if #(.NUM_CARDS(NC)) bus_a ();
    card_dealer_if #(.NUM_CARDS(NC)) bus_b ();

    card_dealer #(.NUM_CARDS(NC), .LFSR_SEED(16'hACE1), .MAX_REJECT(7)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a));
    card_dealer #(.NUM_CARDS(NC), .LFSR_SEED(16'hACE1), .MAX_REJECT(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b));

    typedef struct { logic [63:0] cards; int lat; } exp_t;
    typedef struct { logic [15:0] seed; int hold; exp_t exp; } vec_t;

    int   errors = 0;
    int   checks = 0;
    exp_t sbq[$];
    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] adv(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    function automatic logic [5:0] idx2card(input int i);
        int s;
        int r;
        logic [5:0] c;
        s = i / 13;
        r = i % 13 + 2;
        c = {s[1:0], r[3:0]};
        return c;
    endfunction

    function automatic logic [5:0] rev6(input logic [5:0] c);
        logic [5:0] r;
        for (int j = 0; j < 6; j++) r[j] = c[5-j];
        return r;
    endfunction

    function automatic exp_t model_deal(input logic [15:0] s, input int maxrej);
        exp_t e;
        logic [15:0] l;
        logic [63:0] used;
        logic [5:0] c;
        int rej, k, cyc, idx;
        l = s; used = '0; rej = 0; k = 0; cyc = 0; e.cards = '0;
        while (k < NC) begin
            c = l[5:0];
            idx = -1;
            if (c < 6'd52 && !used[c]) idx = int'(c);
            else if (rej + 1 > maxrej) begin
                for (int i = 0; i < 52; i++) if (idx < 0 && !used[i]) idx = i;
            end else rej++;
            if (idx >= 0) begin
                used[idx] = 1'b1;
                e.cards[6*k +: 6] = rev6(idx2card(idx));
                k++;
                rej = 0;
            end
            l = adv(l);
            cyc++;
        end
        e.lat = cyc + 1;
        return e;
    endfunction

    function automatic bit cards_ok(input logic [63:0] v);
        logic [63:0] seen;
        logic [5:0] c;
        int idx;
        bit ok;
        seen = '0; ok = 1'b1;
        for (int k = 0; k < NC; k++) begin
            for (int j = 0; j < 6; j++) c[5-j] = v[6*k+j];
            if (c[3:0] < 4'd2 || c[3:0] > 4'd14) ok = 1'b0;
            else begin
                idx = int'(c[5:4]) * 13 + int'(c[3:0]) - 2;
                if (seen[idx]) ok = 1'b0;
                seen[idx] = 1'b1;
            end
        end
        return ok;
    endfunction

    task automatic deal_a(input logic [15:0] s, input int hold, input exp_t e);
        exp_t got;
        logic [63:0] snap;
        int n;
        bit seen;
        @(negedge clk) bus_a.draw_card = 1'b1;
        @(negedge clk);
        bus_a.seed_load = 1'b1;
        bus_a.seed = s;
        sbq.push_back(e);
        @(negedge clk) bus_a.seed_load = 1'b0;
        check("lfsr_load", 64'(dut_a.u_lfsr.lfsr_q), 64'((s == 16'h0) ? 16'hACE1 : s));
        n = 0; seen = 1'b0;
        while (!seen && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            seen = bus_a.all_cards_dealt;
        end
        got = sbq.pop_front();
        check("done_seen", 64'(seen), 64'd1);
        check("cards", 64'(bus_a.dealt_cards), got.cards);
        check("latency", 64'(n), 64'(got.lat));
        check("count9", 64'(bus_a.dealt_count), 64'd9);
        check("busy_done", 64'(bus_a.busy), 64'd0);
        check("unique", 64'(cards_ok(64'(bus_a.dealt_cards))), 64'd1);
        snap = 64'(bus_a.dealt_cards);
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            check("hold_flag", 64'(bus_a.all_cards_dealt), 64'd1);
            check("hold_cards", 64'(bus_a.dealt_cards), snap);
        end
        bus_a.draw_card = 1'b0;
        @(negedge clk);
        check("ack_flag", 64'(bus_a.all_cards_dealt), 64'd0);
        check("ack_cards", 64'(bus_a.dealt_cards), snap);
        check("ack_busy", 64'(bus_a.busy), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [15:0] s;
        int n;
        bit seen, flag_seen;

        vecs[0] = '{seed: 16'h1234, hold: 0, exp: model_deal(16'h1234, 7)};
        vecs[1] = '{seed: 16'hACE1, hold: 2, exp: model_deal(16'hACE1, 7)};
        vecs[2] = '{seed: 16'h0000, hold: 1, exp: model_deal(16'hACE1, 7)};
        vecs[3] = '{seed: 16'hFFFF, hold: 0, exp: model_deal(16'hFFFF, 7)};
        vecs[4] = '{seed: 16'h8001, hold: 3, exp: model_deal(16'h8001, 7)};
        vecs[5] = '{seed: 16'h3F3F, hold: 0, exp: model_deal(16'h3F3F, 7)};

        bus_a.draw_card = 1'b0; bus_a.seed_load = 1'b0; bus_a.seed = '0;
        bus_b.draw_card = 1'b0; bus_b.seed_load = 1'b0; bus_b.seed = '0;

        // Power-on reset
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_lfsr", 64'(dut_a.u_lfsr.lfsr_q), 64'h ACE1);
        check("rst_cards", 64'(bus_a.dealt_cards), 64'd0);
        check("rst_count", 64'(bus_a.dealt_count), 64'd0);
        check("rst_flag", 64'(bus_a.all_cards_dealt), 64'd0);
        check("rst_busy", 64'(bus_a.busy), 64'd0);

        for (int i = 0; i < 6; i++) deal_a(vecs[i].seed, vecs[i].hold, vecs[i].exp);

        // Reset asserted in the middle of a deal
        @(negedge clk) bus_a.draw_card = 1'b1;
        repeat (5) @(negedge clk);
        check("mid_busy", 64'(bus_a.busy), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_cards", 64'(bus_a.dealt_cards), 64'd0);
        check("midrst_count", 64'(bus_a.dealt_count), 64'd0);
        check("midrst_busy", 64'(bus_a.busy), 64'd0);
        check("midrst_flag", 64'(bus_a.all_cards_dealt), 64'd0);
        @(negedge clk);
        bus_a.draw_card = 1'b0;
        reset_n = 1'b1;
        #1;
        check("rel_lfsr", 64'(dut_a.u_lfsr.lfsr_q), 64'hACE1);
        check("rel_busy", 64'(bus_a.busy), 64'd0);

        // Abort during CLEAR
        @(negedge clk) bus_a.draw_card = 1'b1;
        @(negedge clk);
        check("clear_busy", 64'(bus_a.busy), 64'd1);
        bus_a.draw_card = 1'b0;
        @(negedge clk);
        check("abort_clr_busy", 64'(bus_a.busy), 64'd0);
        check("abort_clr_count", 64'(bus_a.dealt_count), 64'd0);

        // Abort at dealt_count == 4, then a fresh deal
        @(negedge clk) bus_a.draw_card = 1'b1;
        n = 0; flag_seen = 1'b0;
        while (bus_a.dealt_count != 4'd4 && n < 200) begin
            @(negedge clk);
            n++;
            if (bus_a.all_cards_dealt) flag_seen = 1'b1;
        end
        check("abort_reach4", 64'(bus_a.dealt_count), 64'd4);
        check("abort_busy_draw", 64'(bus_a.busy), 64'd1);
        bus_a.draw_card = 1'b0;
        @(negedge clk);
        check("abort_count", 64'(bus_a.dealt_count), 64'd0);
        check("abort_busy", 64'(bus_a.busy), 64'd0);
        check("abort_flag", 64'(flag_seen | bus_a.all_cards_dealt), 64'd0);
        deal_a(16'h5A5A, 0, model_deal(16'h5A5A, 7));

        // Scan fallback with MAX_REJECT = 0
        @(negedge clk) bus_b.draw_card = 1'b1;
        @(negedge clk);
        bus_b.seed_load = 1'b1;
        bus_b.seed = 16'hFFFF;
        sbq.push_back(model_deal(16'hFFFF, 0));
        @(negedge clk) bus_b.seed_load = 1'b0;
        check("b_lfsr", 64'(dut_b.u_lfsr.lfsr_q), 64'hFFFF);
        @(negedge clk);
        check("b_count1", 64'(bus_b.dealt_count), 64'd1);
        check("b_slot0", 64'(bus_b.dealt_cards[5:0]), 64'h10);
        n = 1; seen = bus_b.all_cards_dealt;
        while (!seen && n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            seen = bus_b.all_cards_dealt;
        end
        e = sbq.pop_front();
        check("b_done", 64'(seen), 64'd1);
        check("b_cards", 64'(bus_b.dealt_cards), e.cards);
        check("b_latency", 64'(n), 64'(e.lat));
        check("b_unique", 64'(cards_ok(64'(bus_b.dealt_cards))), 64'd1);
        bus_b.draw_card = 1'b0;
        @(negedge clk);
        check("b_ack", 64'(bus_b.all_cards_dealt), 64'd0);

        // Randomly seeded deals
        for (int r = 0; r < 1000; r++) begin
            s = 16'($urandom);
            e = model_deal((s == 16'h0) ? 16'hACE1 : s, 7);
            deal_a(s, r % 3, e);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/card_dealer.md
Name: card_dealer

Overview:
- Draws NUM_CARDS distinct cards from a 52-card deck and packs them into a flat bus for the game state machine: 2 player, 2 dealer and 5 community cards.
- Sits directly upstream of the game controller, which raises draw_card, waits for all_cards_dealt, drops draw_card, then samples dealt_cards on the next cycle.
- Randomness comes from a free-running 16-bit LFSR, so the draw depends on how many cycles have elapsed since reset.

Parameters:
- NUM_CARDS, 9: cards dealt per request; dealt_cards width is 6*NUM_CARDS.
- LFSR_SEED, 16'hACE1: LFSR value at reset. A seed of 0 is replaced by 16'hACE1.
- MAX_REJECT, 7: number of consecutive rejected candidates after which the block falls back to a deterministic scan.

Ports:
- clk, input, 1: system clock; all flops are on the rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- draw_card, input, 1: level request. High means deal; low aborts a deal or acknowledges a finished one.
- seed_load, input, 1: loads seed into the LFSR on this cycle (test/entropy hook).
- seed, input, 16: seed value for seed_load; 0 is treated as LFSR_SEED.
- dealt_cards, output, 6*NUM_CARDS: packed cards (layout under Behaviour).
- all_cards_dealt, output, 1: all NUM_CARDS cards are valid and stable.
- dealt_count, output, 4: number of cards accepted so far in the current deal.
- busy, output, 1: high in CLEAR and DRAW.

Behaviour:
- Reset values: dealt_cards=0, all_cards_dealt=0, dealt_count=0, busy=0, used mask=0, reject counter=0, LFSR=LFSR_SEED, state=IDLE.
- Reset mid-deal aborts the deal immediately.
- LFSR:
  - Fibonacci x^16+x^14+x^13+x^11+1: shift left, bit0 <= l[15]^l[13]^l[12]^l[10].
  - Advances every cycle in every state.
  - seed_load overrides the advance for that cycle.
- Card encoding: deck index i in 0..51 maps to card = {suit[1:0], rank[3:0]}, with suit = i/13 and rank = (i mod 13)+2, giving ranks 2..14 (ace = 14).
- Packing:
  - Card k occupies bits 6k..6k+5.
  - The card MSB is at bit 6k and the card LSB at bit 6k+5 (bit-reversed within each slot, matching the controller's concatenation).
  - Card 0 is the first card accepted.
- IDLE:
  - busy=0. Outputs hold their last values.
  - draw_card=1 moves to CLEAR.
- CLEAR (1 cycle):
  - Clears the used mask, dealt_cards, dealt_count and the reject counter.
  - Moves to DRAW.
- DRAW, one candidate per cycle:
  - Candidate c = lfsr[5:0] of the current cycle.
  - Accept if c<52 and used[c]==0: write the slot, set used[c], increment dealt_count, clear the reject counter.
  - Otherwise reject: increment the reject counter.
  - When the reject counter would exceed MAX_REJECT, that cycle instead accepts the lowest-index unused card (priority encoder over ~used) and clears the counter.
  - Worst-case deal length is bounded at NUM_CARDS*(MAX_REJECT+1) cycles.
- DONE:
  - On the cycle after the NUM_CARDS-th accept: all_cards_dealt=1, busy=0.
  - Stays in DONE while draw_card=1.
  - draw_card=0 moves to IDLE and clears all_cards_dealt on the next cycle. dealt_cards is retained for the controller to sample.
- Abort: draw_card=0 in CLEAR or DRAW moves to IDLE next cycle and sets dealt_count=0. Partial dealt_cards is don't-care; all_cards_dealt stays 0.
- Restart: draw_card held high through a full deal stays in DONE; no redeal without a low cycle.
- Latency: minimum is 1 (IDLE to CLEAR) + 1 (CLEAR) + NUM_CARDS accepts + 1. With NUM_CARDS=9, all_cards_dealt rises at the 12th rising edge after draw_card is first sampled high.
- Uniqueness: a card index is never accepted twice within one deal, including under the scan fallback.

Decomposition:
- Shared package (poker_pkg):
  - card width 6, DECK_SIZE 52, RANK_MIN 2, RANK_ACE 14, suit/rank field positions;
  - index_to_card function;
  - slot offsets for player, dealer and community cards (0-1, 2-3, 4-8).
- One natural sub-module: lfsr16, holding the seeded Fibonacci LFSR with the load port and zero-seed guard.
- The FSM, used mask, priority encoder and packing stay in card_dealer.

Test Plan:
- Reset with reset_n=0 asserted mid-DRAW -> all outputs 0 immediately. After release the LFSR equals 16'hACE1 and state is IDLE (busy=0).
- seed_load with seed=16'hFFFF, MAX_REJECT=0, draw_card=1 -> first candidate 63 is rejected, the scan accepts index 0, and slot 0 reads card 6'h02 (suit 0, rank 2) in bit-reversed slot order.
- Default params, draw_card held high -> all_cards_dealt within 2+9*8+1 cycles; 9 distinct cards, each with rank 2..14 and suit 0..3; dealt_count=9.
- After DONE, drop draw_card -> all_cards_dealt=0 next cycle and dealt_cards unchanged for at least 1 cycle.
- draw_card dropped when dealt_count=4 -> IDLE next cycle, dealt_count=0, all_cards_dealt never asserted. Re-raise -> a fresh full deal of 9 unique cards.
- seed_load with seed=0 -> LFSR loads 16'hACE1. Over 1000 random deals, no duplicate card ever appears within a deal.
